// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its program counter, program ROM and ALU flags.
// Optional feature macro: RET_STACK_EN (adds the sticky stack_err flag).
interface fetch_sequencer_if;
  localparam int unsigned PC_W   = 12;
  localparam int unsigned BYTE_W = 8;

  logic              stall;
  logic [PC_W-1:0]   pc;
  logic [BYTE_W-1:0] rom_data;
  logic              flag_z;
  logic              flag_c;
  logic              pc_enable;
  logic              pc_load;
  logic [PC_W-1:0]   pc_load_data;
  logic [BYTE_W-1:0] instr;
  logic              instr_valid;
`ifdef RET_STACK_EN
  logic              stack_err;

  modport master (
    input  stall, pc, rom_data, flag_z, flag_c,
    output pc_enable, pc_load, pc_load_data, instr, instr_valid, stack_err
  );
  modport slave (
    output stall, pc, rom_data, flag_z, flag_c,
    input  pc_enable, pc_load, pc_load_data, instr, instr_valid, stack_err
  );
`else
  modport master (
    input  stall, pc, rom_data, flag_z, flag_c,
    output pc_enable, pc_load, pc_load_data, instr, instr_valid
  );
  modport slave (
    output stall, pc, rom_data, flag_z, flag_c,
    input  pc_enable, pc_load, pc_load_data, instr, instr_valid
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steers the program counter, latches instructions, resolves jumps.
// Optional feature macro: RET_STACK_EN (4-entry CALL/RET return stack with sticky stack_err).
module fetch_sequencer (
  input  logic              CLK,
  input  logic              reset,
  fetch_sequencer_if.master bus
);
  localparam int unsigned PC_W    = 12;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned OP_W    = 4;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hA;
  localparam logic [OP_W-1:0] OP_JZ   = 4'hB;
  localparam logic [OP_W-1:0] OP_JC   = 4'hC;
`ifdef RET_STACK_EN
  localparam logic [OP_W-1:0] OP_CALL = 4'hD;
  localparam logic [OP_W-1:0] OP_RET  = 4'hE;
  localparam int unsigned STK_D   = 4;
  localparam int unsigned DEPTH_W = 3;
`endif

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_FETCH2 = 2'd1, S_EXEC = 2'd2} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BYTE_W-1:0] r_instr;
  logic              w_latch;
  logic              w_en;
  logic              w_load;
  logic [PC_W-1:0]   w_load_data;
  logic              w_valid;
  logic [OP_W-1:0]   w_op_fetch;
  logic [OP_W-1:0]   w_op_instr;
  logic              w_two_byte;
  logic              w_taken;
  logic [PC_W-1:0]   w_target;

  assign w_op_fetch = bus.rom_data[BYTE_W-1 -: OP_W];
  assign w_op_instr = r_instr[BYTE_W-1 -: OP_W];
  assign w_target   = {r_instr[OP_W-1:0], bus.rom_data};

`ifdef RET_STACK_EN
  logic [PC_W-1:0]    r_stack [STK_D];
  logic [DEPTH_W-1:0] r_depth;
  logic               r_stack_err;
  logic               w_push;
  logic               w_pop;
  logic [PC_W-1:0]    w_stack_top;

  assign w_two_byte  = (w_op_fetch == OP_JMP) || (w_op_fetch == OP_JZ) ||
                       (w_op_fetch == OP_JC)  || (w_op_fetch == OP_CALL);
  assign w_taken     = (w_op_instr == OP_JMP) || (w_op_instr == OP_CALL) ||
                       ((w_op_instr == OP_JZ) && bus.flag_z) ||
                       ((w_op_instr == OP_JC) && bus.flag_c);
  assign w_stack_top = (r_depth == '0) ? '0 : r_stack[0];
`else
  assign w_two_byte  = (w_op_fetch == OP_JMP) || (w_op_fetch == OP_JZ) || (w_op_fetch == OP_JC);
  assign w_taken     = (w_op_instr == OP_JMP) ||
                       ((w_op_instr == OP_JZ) && bus.flag_z) ||
                       ((w_op_instr == OP_JC) && bus.flag_c);
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) r_instr <= bus.rom_data;
    end
  end

  // Next state and counter controls; a stall leaves everything at its inactive default.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_en        = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    w_valid     = 1'b0;
`ifdef RET_STACK_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
`endif
    if (!bus.stall) begin
      case (r_state)
        S_FETCH: begin
          w_latch = 1'b1;
          if (w_two_byte) begin
            w_en        = 1'b1;
            w_state_nxt = S_FETCH2;
`ifdef RET_STACK_EN
          end else if (w_op_fetch == OP_RET) begin
            w_load      = 1'b1;
            w_load_data = w_stack_top;
            w_pop       = 1'b1;
`endif
          end else begin
            w_en        = 1'b1;
            w_state_nxt = S_EXEC;
          end
        end
        S_FETCH2: begin
          if (w_taken) begin
            w_load      = 1'b1;
            w_load_data = w_target;
`ifdef RET_STACK_EN
            w_push      = (w_op_instr == OP_CALL);
`endif
          end else begin
            w_en = 1'b1;
          end
          w_state_nxt = S_FETCH;
        end
        S_EXEC: begin
          w_valid     = 1'b1;
          w_state_nxt = S_FETCH;
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

`ifdef RET_STACK_EN
  // Newest entry lives at index 0; a push when full shifts the oldest out the bottom.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STK_D; i++) r_stack[i] <= '0;
      r_depth     <= '0;
      r_stack_err <= 1'b0;
    end else if (w_push) begin
      for (int i = STK_D - 1; i > 0; i--) r_stack[i] <= r_stack[i-1];
      r_stack[0] <= PC_W'(bus.pc + 12'd1);
      if (r_depth == DEPTH_W'(STK_D)) r_stack_err <= 1'b1;
      else                           r_depth     <= r_depth + 3'd1;
    end else if (w_pop) begin
      if (r_depth == '0) begin
        r_stack_err <= 1'b1;
      end else begin
        for (int i = 0; i < STK_D - 1; i++) r_stack[i] <= r_stack[i+1];
        r_stack[STK_D-1] <= '0;
        r_depth          <= r_depth - 3'd1;
      end
    end
  end

  assign bus.stack_err = r_stack_err;
`endif

  // Everything is held at zero while reset is asserted.
  assign bus.pc_enable    = reset & w_en;
  assign bus.pc_load      = reset & w_load;
  assign bus.pc_load_data = reset ? w_load_data : '0;
  assign bus.instr_valid  = reset & w_valid;
  assign bus.instr        = r_instr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a behavioural counter, ROM and instruction-level model.
// Compile with RET_STACK_EN defined to also exercise the return stack.
module tb_fetch_sequencer;
`ifdef RET_STACK_EN
  localparam bit STACK = 1'b1;
`else
  localparam bit STACK = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic reset = 1'b0;
  fetch_sequencer_if bus ();

  fetch_sequencer dut (.CLK(CLK), .reset(reset), .bus(bus));

  always #5 CLK = ~CLK;

  logic [7:0]  rom [4096];
  logic [11:0] pc_q;
  logic        set_req;
  logic [11:0] set_val;
  logic [14:0] w_outs;
  int          n_vec = 0;
  int          n_err = 0;

  assign bus.pc       = pc_q;
  assign bus.rom_data = rom[pc_q];
  assign w_outs       = {bus.pc_enable, bus.pc_load, bus.pc_load_data, bus.instr_valid};

  // Program counter being driven: load wins over enable.
  always @(posedge CLK) begin
    if (set_req)          pc_q <= set_val;
    else if (bus.pc_load) pc_q <= bus.pc_load_data;
    else if (bus.pc_enable) pc_q <= pc_q + 12'd1;
  end

  function automatic logic [14:0] outs(input logic en, input logic ld, input logic [11:0] d,
                                       input logic v);
    return {en, ld, d, v};
  endfunction

  task automatic restart(input logic [11:0] start);
    @(negedge CLK);
    reset = 1'b0; bus.stall = 1'b0; set_val = start; set_req = 1'b1;
    @(negedge CLK);
    set_req = 1'b0; reset = 1'b1;
  endtask

  task automatic test_reset();
    rom[0] = 8'h35;
    set_val = 12'h000; set_req = 1'b1; reset = 1'b0; bus.stall = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    n_vec++;
    if (w_outs !== 15'h0 || bus.instr !== 8'h00) begin
      n_err++; $display("FAIL reset_outs: outs=%h instr=%h want 0/00", w_outs, bus.instr);
    end
`ifdef RET_STACK_EN
    n_vec++;
    if (bus.stack_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.stack_err); end
`endif
    set_req = 1'b0; reset = 1'b1; #1;
    n_vec++;
    if (w_outs !== outs(1, 0, 12'h0, 0)) begin
      n_err++; $display("FAIL first_fetch: outs=%h want %h", w_outs, outs(1, 0, 12'h0, 0));
    end
    @(negedge CLK); #1;
    n_vec++;
    if (w_outs !== outs(0, 0, 12'h0, 1) || bus.instr !== 8'h35 || pc_q !== 12'h001) begin
      n_err++; $display("FAIL first_exec: outs=%h instr=%h pc=%h want %h/35/001", w_outs, bus.instr, pc_q,
                        outs(0, 0, 12'h0, 1));
    end
    @(negedge CLK); #1;
    n_vec++;
    if (bus.instr_valid !== 1'b0 || pc_q !== 12'h001) begin
      n_err++; $display("FAIL single_pulse: valid=%b pc=%h want 0/001", bus.instr_valid, pc_q);
    end
  endtask

  task automatic test_jmp();
    rom[12'h000] = 8'hA4; rom[12'h001] = 8'h56;
    restart(12'h000);
    @(negedge CLK); #1;
    n_vec++;
    if (w_outs !== outs(0, 1, 12'h456, 0) || bus.instr !== 8'hA4) begin
      n_err++; $display("FAIL jmp_load: outs=%h instr=%h want %h/A4", w_outs, bus.instr, outs(0, 1, 12'h456, 0));
    end
    @(negedge CLK); #1;
    n_vec++;
    if (pc_q !== 12'h456 || bus.instr_valid !== 1'b0) begin
      n_err++; $display("FAIL jmp_pc: pc=%h valid=%b want 456/0", pc_q, bus.instr_valid);
    end
  endtask

  task automatic test_jz();
    rom[12'h010] = 8'hB1; rom[12'h011] = 8'h00;
    for (int z = 0; z < 2; z++) begin
      restart(12'h010);
      bus.flag_z = 1'(z); bus.flag_c = 1'b0;
      @(negedge CLK); #1;
      n_vec++;
      if (w_outs !== ((z == 1) ? outs(0, 1, 12'h100, 0) : outs(1, 0, 12'h0, 0))) begin
        n_err++; $display("FAIL jz_ctrl z=%0d: outs=%h", z, w_outs);
      end
      @(negedge CLK); #1;
      n_vec++;
      if (pc_q !== ((z == 1) ? 12'h100 : 12'h012)) begin
        n_err++; $display("FAIL jz_pc z=%0d: pc=%h want %h", z, pc_q, (z == 1) ? 12'h100 : 12'h012);
      end
    end
  endtask

  task automatic test_stall();
    rom[12'h020] = 8'h35;
    restart(12'h020);
    @(negedge CLK);
    for (int s = 0; s < 3; s++) begin
      bus.stall = 1'b1; #1;
      n_vec++;
      if (w_outs !== 15'h0 || pc_q !== 12'h021) begin
        n_err++; $display("FAIL stall_exec %0d: outs=%h pc=%h want 0/021", s, w_outs, pc_q);
      end
      @(negedge CLK);
    end
    bus.stall = 1'b0; #1;
    n_vec++;
    if (w_outs !== outs(0, 0, 12'h0, 1) || bus.instr !== 8'h35 || pc_q !== 12'h021) begin
      n_err++; $display("FAIL stall_resume: outs=%h instr=%h pc=%h", w_outs, bus.instr, pc_q);
    end
    @(negedge CLK); #1;
    n_vec++;
    if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_once: valid=%b want 0", bus.instr_valid); end
  endtask

  task automatic test_reset_abort();
    rom[12'h030] = 8'hA4; rom[12'h031] = 8'h56;
    restart(12'h030);
    @(negedge CLK);
    reset = 1'b0; #1;
    n_vec++;
    if (w_outs !== 15'h0 || bus.instr !== 8'h00) begin
      n_err++; $display("FAIL abort_outs: outs=%h instr=%h want 0/00", w_outs, bus.instr);
    end
    @(negedge CLK);
    reset = 1'b1; #1;
    n_vec++;
    if (pc_q !== 12'h031 || w_outs !== outs(1, 0, 12'h0, 0)) begin
      n_err++; $display("FAIL abort_restart: pc=%h outs=%h want 031/%h", pc_q, w_outs, outs(1, 0, 12'h0, 0));
    end
  endtask

`ifdef RET_STACK_EN
  task automatic test_stack();
    rom[12'h0FE] = 8'hD2; rom[12'h0FF] = 8'h00; rom[12'h200] = 8'hE0;
    restart(12'h0FE);
    @(negedge CLK); @(negedge CLK); #1;
    n_vec++;
    if (pc_q !== 12'h200 || w_outs !== outs(0, 1, 12'h100, 0)) begin
      n_err++; $display("FAIL call_ret: pc=%h outs=%h want 200/%h", pc_q, w_outs, outs(0, 1, 12'h100, 0));
    end
    @(negedge CLK); #1;
    n_vec++;
    if (pc_q !== 12'h100) begin n_err++; $display("FAIL ret_pc: pc=%h want 100", pc_q); end
    for (int k = 0; k < 5; k++) begin
      rom[12'h400 + 12'(3*k)] = 8'hD4;
      rom[12'h401 + 12'(3*k)] = 8'(3*k + 3);
    end
    restart(12'h400);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK); @(negedge CLK); #1;
      n_vec++;
      if (bus.stack_err !== ((k == 5) ? 1'b1 : 1'b0) || pc_q !== 12'h400 + 12'(3*k)) begin
        n_err++; $display("FAIL nest_call %0d: err=%b pc=%h", k, bus.stack_err, pc_q);
      end
    end
    rom[12'h500] = 8'hE0;
    restart(12'h500); #1;
    n_vec++;
    if (w_outs !== outs(0, 1, 12'h000, 0)) begin
      n_err++; $display("FAIL empty_ret: outs=%h want %h", w_outs, outs(0, 1, 12'h000, 0));
    end
    @(negedge CLK); #1;
    n_vec++;
    if (pc_q !== 12'h000 || bus.stack_err !== 1'b1) begin
      n_err++; $display("FAIL empty_ret_pc: pc=%h err=%b want 000/1", pc_q, bus.stack_err);
    end
  endtask
`endif

  // Random stall cycles ahead of a phase; leaves the cycle unstalled with fresh flags applied.
  task automatic stall_burst(input logic [11:0] pc_hold);
    int n;
    n = $urandom_range(0, 2);
    for (int s = 0; s < n; s++) begin
      bus.stall = 1'b1; bus.flag_z = 1'($urandom); bus.flag_c = 1'($urandom); #1;
      n_vec++;
      if (w_outs !== 15'h0 || pc_q !== pc_hold) begin
        n_err++; $display("FAIL stall_hold: outs=%h pc=%h want 0/%h", w_outs, pc_q, pc_hold);
      end
      @(negedge CLK);
    end
    bus.stall = 1'b0; bus.flag_z = 1'($urandom); bus.flag_c = 1'($urandom); #1;
  endtask

  task automatic test_random();
    logic [11:0] stk[$];
    logic        err;
    logic [11:0] pc0, tgt, exp_pc;
    logic [7:0]  b0;
    logic [3:0]  op;
    logic        two, ret, taken;
    for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom);
    restart(12'($urandom));
    stk.delete(); err = 1'b0;
    for (int k = 0; k < 300; k++) begin
      pc0 = pc_q; b0 = rom[pc0]; op = b0[7:4];
      two = (op == 4'hA) || (op == 4'hB) || (op == 4'hC) || (STACK && op == 4'hD);
      ret = STACK && (op == 4'hE);
      stall_burst(pc0);
      if (ret) begin
        if (stk.size() == 0) begin exp_pc = 12'h000; err = 1'b1; end
        else exp_pc = stk.pop_front();
        n_vec++;
        if (w_outs !== outs(0, 1, exp_pc, 0)) begin
          n_err++; $display("FAIL rnd_ret @%h: outs=%h want %h", pc0, w_outs, outs(0, 1, exp_pc, 0));
        end
      end else begin
        n_vec++;
        if (w_outs !== outs(1, 0, 12'h0, 0)) begin
          n_err++; $display("FAIL rnd_fetch @%h: outs=%h want %h", pc0, w_outs, outs(1, 0, 12'h0, 0));
        end
        @(negedge CLK);
        stall_burst(12'(pc0 + 12'd1));
        if (two) begin
          tgt   = {b0[3:0], rom[12'(pc0 + 12'd1)]};
          taken = (op == 4'hA) || (op == 4'hD) || (op == 4'hB && bus.flag_z) || (op == 4'hC && bus.flag_c);
          exp_pc = taken ? tgt : 12'(pc0 + 12'd2);
          if (op == 4'hD) begin
            stk.push_front(12'(pc0 + 12'd2));
            if (stk.size() > 4) begin void'(stk.pop_back()); err = 1'b1; end
          end
          n_vec++;
          if (w_outs !== (taken ? outs(0, 1, tgt, 0) : outs(1, 0, 12'h0, 0)) || bus.instr !== b0) begin
            n_err++; $display("FAIL rnd_fetch2 @%h op=%h: outs=%h instr=%h taken=%b", pc0, op, w_outs,
                              bus.instr, taken);
          end
        end else begin
          exp_pc = 12'(pc0 + 12'd1);
          n_vec++;
          if (w_outs !== outs(0, 0, 12'h0, 1) || bus.instr !== b0) begin
            n_err++; $display("FAIL rnd_exec @%h: outs=%h instr=%h want %h/%h", pc0, w_outs, bus.instr,
                              outs(0, 0, 12'h0, 1), b0);
          end
        end
      end
      @(negedge CLK);
      n_vec++;
      if (pc_q !== exp_pc) begin n_err++; $display("FAIL rnd_pc @%h: pc=%h want %h", pc0, pc_q, exp_pc); end
`ifdef RET_STACK_EN
      n_vec++;
      if (bus.stack_err !== err) begin n_err++; $display("FAIL rnd_err @%h: got %b want %b", pc0, bus.stack_err, err); end
`endif
    end
  endtask

  initial begin
    set_req = 1'b0; set_val = 12'h000; bus.stall = 1'b0; bus.flag_z = 1'b0; bus.flag_c = 1'b0;
    for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
    test_reset();
    test_jmp();
    test_jz();
    test_stall();
    test_reset_abort();
`ifdef RET_STACK_EN
    test_stack();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
